conv1d_ntap_stream: RTL

//  Parametrised N-tap 1D convolution (FIR) engine for sample/pixel streams.

---
 rtl/conv1d_pkg.sv | 43 ++++
 rtl/conv1d_coef_bank.sv | 33 +++
 rtl/conv1d_ntap_stream.sv | 124 ++++++++++++
 3 files changed

// File: rtl/conv1d_pkg.sv
`default_nettype none
// ---- conv1d_pkg: accumulator sizing, coefficient typedef, shift/saturate helper -- Rev 1.0 ----
package conv1d_pkg;

  localparam int SAT_W      = 64;
  localparam int DEF_TAPS   = 3;
  localparam int DEF_COEF_W = 8;

  typedef logic signed [DEF_COEF_W-1:0] coef_arr_t [DEF_TAPS];

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] val;
  } sat_res_t;

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + 1 + $clog2(taps);
  endfunction

  // Floor shift, then clamp into an out_w-bit signed range; sat flags any clamp.
  function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] acc,
                                         input int shift, input int out_w);
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                res;
    sh = acc >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    res.sat = 1'b0;
    res.val = sh;
    if (sh > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (sh < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv1d_coef_bank.sv
`default_nettype none
// ---- conv1d_coef_bank: TAPS x COEF_W coefficient registers, flat parallel read -- Rev 1.0 ----
module conv1d_coef_bank #(
  parameter int COEF_W = 8,
  parameter int TAPS   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(TAPS)-1:0]  wr_addr,
  input  logic [COEF_W-1:0]        wr_data,
  output logic [TAPS*COEF_W-1:0]   coef_flat
);

  logic [COEF_W-1:0] r_coef [TAPS];

  // Addresses at or beyond TAPS match no entry and are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_coef <= '{default: '0};
    end else if (wr_en) begin
      for (int i = 0; i < TAPS; i++) begin
        if (32'(wr_addr) == i) r_coef[i] <= wr_data;
      end
    end
  end

  for (genvar i = 0; i < TAPS; i++) begin : g_flat
    assign coef_flat[i*COEF_W +: COEF_W] = r_coef[i];
  end

endmodule
`default_nettype wire

// File: rtl/conv1d_ntap_stream.sv
`default_nettype none
// ---- conv1d_ntap_stream: streaming N-tap FIR, window -> product -> result pipeline -- Rev 1.0 ----
module conv1d_ntap_stream
  import conv1d_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int TAPS      = 3,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    coef_wr_en,
  input  logic [$clog2(TAPS)-1:0] coef_wr_addr,
  input  logic [COEF_W-1:0]       coef_wr_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_frame_start,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int FILL_W = $clog2(TAPS + 1);
  localparam logic [FILL_W-1:0] C_FILL_FULL = FILL_W'(TAPS);

  logic                     w_adv;
  logic                     w_accept;
  logic [TAPS*COEF_W-1:0]   w_coef_flat;
  logic signed [COEF_W-1:0] w_coef [TAPS];
  logic [FILL_W-1:0]        w_fill_next;
  logic signed [ACC_W-1:0]  w_acc;
  sat_res_t                 w_sat;

  logic [DATA_W-1:0]        r_win [TAPS];
  logic [FILL_W-1:0]        r_fill;
  logic                     r_win_valid;
  logic signed [PROD_W-1:0] r_prod [TAPS];
  logic                     r_prod_valid;

  // A single advance enable stalls every stage together, so nothing is lost or duplicated.
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv & ~reset;
  assign w_accept = in_valid & in_ready;

  conv1d_coef_bank #(
    .COEF_W (COEF_W),
    .TAPS   (TAPS)
  ) u_coef_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (coef_wr_en),
    .wr_addr   (coef_wr_addr),
    .wr_data   (coef_wr_data),
    .coef_flat (w_coef_flat)
  );

  for (genvar k = 0; k < TAPS; k++) begin : g_coef
    assign w_coef[k] = $signed(w_coef_flat[k*COEF_W +: COEF_W]);
  end

  always_comb begin
    w_fill_next = r_fill;
    if (in_frame_start)              w_fill_next = FILL_W'(1);
    else if (r_fill != C_FILL_FULL)  w_fill_next = r_fill + FILL_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win       <= '{default: '0};
      r_fill      <= '0;
      r_win_valid <= 1'b0;
    end else if (w_adv) begin
      r_win_valid <= w_accept && (w_fill_next == C_FILL_FULL);
      if (w_accept) begin
        r_fill   <= w_fill_next;
        r_win[0] <= in_data;
        for (int k = 1; k < TAPS; k++) begin
          r_win[k] <= in_frame_start ? '0 : r_win[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prod       <= '{default: '0};
      r_prod_valid <= 1'b0;
    end else if (w_adv) begin
      r_prod_valid <= r_win_valid;
      for (int k = 0; k < TAPS; k++) begin
        r_prod[k] <= $signed({1'b0, r_win[k]}) * w_coef[k];
      end
    end
  end

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_acc = w_acc + ACC_W'(r_prod[k]);
    end
  end

  assign w_sat = sat_shift(SAT_W'(w_acc), OUT_SHIFT, OUT_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_prod_valid;
      out_data  <= OUT_W'(w_sat.val);
      out_sat   <= w_sat.sat;
    end
  end

endmodule
`default_nettype wire
